// File: rtl/spu_arf_key_seq_pkg.sv
// rtl/spu_arf_key_seq_pkg.sv - shared types and constants for the round-key sequencer
package spu_arf_key_seq_pkg;

    localparam int KIDX_W = 4;

    localparam logic [KIDX_W-1:0] AES128_ROUNDS = 4'd10;
    localparam logic [KIDX_W-1:0] AES192_ROUNDS = 4'd12;
    localparam logic [KIDX_W-1:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic legal_rounds(input logic [KIDX_W-1:0] n);
        return (n == AES128_ROUNDS) || (n == AES192_ROUNDS) || (n == AES256_ROUNDS);
    endfunction

endpackage

// File: rtl/spu_arf_key_seq_cnt.sv
// rtl/spu_arf_key_seq_cnt.sv - sequence index counter with modulo-16 address and terminal detect
module spu_arf_key_seq_cnt
    import spu_arf_key_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic [KIDX_W-1:0] i_base,
    input  logic [KIDX_W-1:0] i_total,
    output logic [KIDX_W-1:0] o_cnt,
    output logic [KIDX_W-1:0] o_addr,
    output logic              o_term
);

    logic [KIDX_W-1:0] r_cnt;
    logic [KIDX_W-1:0] r_base;
    logic [KIDX_W-1:0] r_total;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_base  <= '0;
            r_total <= '0;
        end else if (i_load) begin
            r_cnt   <= '0;
            r_base  <= i_base;
            r_total <= i_total;
        end else if (i_adv) begin
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    // 4-bit add wraps naturally, giving the modulo-16 entry address
    assign o_cnt  = r_cnt;
    assign o_addr = r_base + r_cnt;
    assign o_term = (r_cnt == r_total - 4'd1);

endmodule

// File: rtl/spu_arf_key_seq.sv
// rtl/spu_arf_key_seq.sv - AES round-key read sequencer with key-load arbitration for the key array
module spu_arf_key_seq
    import spu_arf_key_seq_pkg::*;
#(
    parameter int NKEY_MAX = 15
) (
    input  logic              l2clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [3:0]        ld_addr,
    input  logic              ld_half,
    input  logic [63:0]       ld_data,
    output logic              ld_ready,
    input  logic              ks_start,
    input  logic [3:0]        ks_base,
    input  logic [3:0]        ks_nrounds,
    input  logic              ks_stall,
    input  logic              ks_abort,
    output logic              ks_busy,
    output logic              ks_key_valid,
    output logic [3:0]        ks_key_idx,
    output logic              ks_last,
    output logic              ks_err,
    output logic              arf_rd_enable,
    output logic [3:0]        arf_rd_addr,
    output logic [1:0]        arf_wr_enable,
    output logic [3:0]        arf_wr_addr,
    output logic [63:0]       arf_wr_data
);

    state_e            r_state;
    logic              r_err;
    logic              r_kv;
    logic              r_last;
    logic [KIDX_W-1:0] r_kidx;

    logic              w_legal;
    logic              w_load;
    logic              w_rd;
    logic              w_wr;
    logic              w_term;
    logic [KIDX_W-1:0] w_cnt;
    logic [KIDX_W-1:0] w_addr;
    logic [KIDX_W-1:0] w_total;

    assign w_legal = legal_rounds(ks_nrounds) && (({28'd0, ks_nrounds} + 32'd1) <= NKEY_MAX);
    assign w_total = ks_nrounds + 4'd1;
    assign w_load  = (r_state == ST_IDLE) && ks_start && w_legal;
    assign w_rd    = (r_state == ST_RUN) && !ks_stall && !rst;

    spu_arf_key_seq_cnt u_cnt (
        .i_clk   (l2clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_adv   (w_rd),
        .i_base  (ks_base),
        .i_total (w_total),
        .o_cnt   (w_cnt),
        .o_addr  (w_addr),
        .o_term  (w_term)
    );

    // Reads win a same-entry collision; the load beat simply waits a cycle
    assign ld_ready      = !(w_rd && (w_addr == ld_addr));
    assign w_wr          = ld_valid && ld_ready && !rst;
    assign arf_wr_enable = w_wr ? (ld_half ? 2'b10 : 2'b01) : 2'b00;
    assign arf_wr_addr   = rst ? 4'd0 : ld_addr;
    assign arf_wr_data   = rst ? 64'd0 : ld_data;

    assign arf_rd_enable = w_rd;
    assign arf_rd_addr   = rst ? 4'd0 : w_addr;

    assign ks_busy       = (r_state != ST_IDLE);
    assign ks_key_valid  = r_kv;
    assign ks_key_idx    = r_kidx;
    assign ks_last       = r_last;
    assign ks_err        = r_err;

    always_ff @(posedge l2clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
            r_kv    <= 1'b0;
            r_last  <= 1'b0;
            r_kidx  <= '0;
        end else begin
            r_err  <= 1'b0;
            r_kv   <= w_rd;
            r_last <= w_rd && w_term;
            if (w_rd) begin
                r_kidx <= w_cnt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ks_start) begin
                        if (w_legal) r_state <= ST_RUN;
                        else         r_err   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ks_abort)           r_state <= ST_IDLE;
                    else if (w_rd && w_term) r_state <= ST_DRAIN;
                end
                ST_DRAIN: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
